// File: rtl/io_controller.sv
// Single-clock I/O sequencer: step-rate tick, debounced button, and a stall FSM
// that holds the CPU on IN, OUT and HALT until the operator acknowledges.
module io_controller #(
   parameter int DIV        = 2500000,
   parameter int DEB_CYCLES = 16,
   parameter int SW_W       = 18,
   parameter int DATA_W     = 28
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              button_in,
   input  logic [SW_W-1:0]   switches,
   input  logic              op_in,
   input  logic              op_out,
   input  logic              op_halt,
   input  logic [DATA_W-1:0] out_data,
   output logic              cpu_en,
   output logic [SW_W-1:0]   in_data,
   output logic [DATA_W-1:0] display,
   output logic              display_valid,
   output logic              heartbeat,
   output logic [2:0]        state
);

   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW = $clog2(DEB_CYCLES + 1);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      WAIT_IN  = 3'd1,
      WAIT_OUT = 3'd2,
      STEP     = 3'd3,
      HALTED   = 3'd4
   } state_t;

   state_t        fsm;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          sync_meta;
   logic          sync;
   logic          deb;
   logic          deb_prev;
   logic [DW-1:0] deb_cnt;
   logic          press;
   logic          any_op;

   assign tick   = (tick_cnt == TW'(DIV - 1));
   assign press  = deb & ~deb_prev;
   assign any_op = op_halt | op_in | op_out;

   // NOTE: every register below uses <= so all flops sample the pre-edge values together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt  <= '0;
         heartbeat <= 1'b0;
      end else if (tick) begin
         tick_cnt  <= '0;
         heartbeat <= ~heartbeat;
      end else begin
         tick_cnt  <= tick_cnt + TW'(1);
      end
   end

   // Level changes only after DEB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
         deb       <= 1'b0;
         deb_prev  <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         sync_meta <= button_in;
         sync      <= sync_meta;
         deb_prev  <= deb;
         if (sync == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb     <= sync;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm     <= RUN;
         in_data <= '0;
         display <= '0;
      end else begin
         case (fsm)
            RUN: begin
               if (tick) begin
                  if (op_halt) begin
                     fsm <= HALTED;
                  end else if (op_in) begin
                     fsm <= WAIT_IN;
                  end else if (op_out) begin
                     fsm     <= WAIT_OUT;
                     display <= out_data;
                  end
               end
            end
            WAIT_IN: begin
               if (press) begin
                  in_data <= switches;
                  fsm     <= STEP;
               end
            end
            WAIT_OUT: begin
               if (press) fsm <= STEP;
            end
            STEP:    fsm <= RUN;
            HALTED:  fsm <= HALTED;
            default: fsm <= RUN;
         endcase
      end
   end

   // The RUN enable must see this cycle's decode, so it stays combinational.
   assign cpu_en        = (fsm == STEP) || ((fsm == RUN) && tick && !any_op);
   assign display_valid = (fsm == WAIT_OUT);
   assign state         = fsm;

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: table of tick-edge decisions, hand-written button and
// reset sequences, and a queue of expected cpu_en cycles checked by a monitor.
module tb_io_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       button_in = 1'b0;
   logic [7:0] switches = 8'h00;
   logic       op_in = 1'b0;
   logic       op_out = 1'b0;
   logic       op_halt = 1'b0;
   logic [7:0] out_data = 8'h00;
   logic       cpu_en;
   logic [7:0] in_data;
   logic [7:0] display;
   logic       display_valid;
   logic       heartbeat;
   logic [2:0] state;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int exp_q[$];

   io_controller #(.DIV(4), .DEB_CYCLES(3), .SW_W(8), .DATA_W(8)) dut (
      .clock(clock), .reset(reset), .button_in(button_in), .switches(switches),
      .op_in(op_in), .op_out(op_out), .op_halt(op_halt), .out_data(out_data),
      .cpu_en(cpu_en), .in_data(in_data), .display(display),
      .display_valid(display_valid), .heartbeat(heartbeat), .state(state)
   );

   always #5 clock = ~clock;

   // Edges since reset release.
   always @(posedge clock or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, exp);
   endtask

   // Every cpu_en pulse must match the oldest expected cycle.
   always @(negedge clock) begin
      if (!reset && cpu_en) begin
         if (exp_q.size() == 0) check("cpu_en_spurious", {31'd0, cpu_en}, 32'd0);
         else check("cpu_en_cycle", cyc, exp_q.pop_front());
      end
   end

   task automatic wait_cyc(input int n);
      int guard = 0;
      do begin
         @(negedge clock);
         guard++;
      end while (cyc < n && guard < 1000);
      if (cyc != n) begin
         n_total++;
         $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, n);
      end
   endtask

   task automatic drive(input logic i, input logic o, input logic h,
                        input logic [7:0] sw, input logic [7:0] od);
      #1;
      op_in = i; op_out = o; op_halt = h; switches = sw; out_data = od;
   endtask

   task automatic set_button(input logic v);
      #1 button_in = v;
   endtask

   task automatic do_reset();
      check("sb_drained", exp_q.size(), 0);
      #2;
      reset = 1'b1;
      op_in = 1'b0; op_out = 1'b0; op_halt = 1'b0; button_in = 1'b0;
      #1;
      check("rst_state", state, 0);
      check("rst_cpu_en", cpu_en, 0);
      check("rst_in_data", in_data, 0);
      check("rst_display", display, 0);
      check("rst_valid", display_valid, 0);
      check("rst_heartbeat", heartbeat, 0);
      exp_q.delete();
      repeat (2) @(negedge clock);
      check("rst_hold_cpu_en", cpu_en, 0);
      #2 reset = 1'b0;
   endtask

   typedef struct {
      logic       i, o, h;
      logic [7:0] od;
      logic [2:0] st;
      logic       en;
      logic [7:0] disp;
      logic       vld;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h11, 3'd0, 1'b1, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h22, 3'd1, 1'b0, 8'h00, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h3C, 3'd2, 1'b0, 8'h3C, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h44, 3'd4, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h99, 3'd4, 1'b0, 8'h00, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h55, 3'd1, 1'b0, 8'h00, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h66, 3'd4, 1'b0, 8'h00, 1'b0};

      // Free run: pulses at 3, 7, 11, 15 and heartbeat toggling on each tick.
      do_reset();
      exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(11); exp_q.push_back(15);
      for (int c = 1; c <= 16; c++) begin
         wait_cyc(c);
         check("free_state", state, 0);
         check("free_heartbeat", heartbeat, (c / 4) % 2);
      end

      // Tick-edge decisions, including halt > in > out priority.
      for (int k = 0; k < 7; k++) begin
         do_reset();
         drive(vecs[k].i, vecs[k].o, vecs[k].h, 8'h00, vecs[k].od);
         if (vecs[k].en) exp_q.push_back(3);
         wait_cyc(2);
         check("vec_offtick_state", state, 0);
         check("vec_offtick_display", display, 0);
         wait_cyc(3);
         check("vec_tick_cpu_en", cpu_en, vecs[k].en);
         wait_cyc(4);
         check("vec_state", state, vecs[k].st);
         check("vec_display", display, vecs[k].disp);
         check("vec_valid", display_valid, vecs[k].vld);
      end

      // IN: wait, press, capture, single step.
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'h00);
      wait_cyc(3);
      check("in_tick_cpu_en", cpu_en, 0);
      wait_cyc(4);
      check("in_wait_state", state, 1);
      wait_cyc(5);
      set_button(1'b1);
      exp_q.push_back(11);
      wait_cyc(10);
      check("in_press_state", state, 1);
      check("in_pre_capture", in_data, 0);
      wait_cyc(11);
      check("in_step_state", state, 3);
      check("in_step_data", in_data, 8'hA5);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      wait_cyc(12);
      check("in_run_state", state, 0);
      check("in_data_hold", in_data, 8'hA5);
      exp_q.push_back(15);
      wait_cyc(15);
      set_button(1'b0);

      // OUT: capture on tick, glitches ignored, press acknowledges.
      wait_cyc(16);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h3C);
      wait_cyc(20);
      check("out_wait_state", state, 2);
      check("out_display", display, 8'h3C);
      check("out_valid", display_valid, 1);
      for (int c = 21; c <= 34; c++) begin
         wait_cyc(c);
         if (c == 21 || c == 26) set_button(1'b1);
         if (c == 22 || c == 28) set_button(1'b0);
         check("glitch_state", state, 2);
      end
      wait_cyc(35);
      set_button(1'b1);
      exp_q.push_back(41);
      wait_cyc(40);
      check("out_press_state", state, 2);
      check("out_press_valid", display_valid, 1);
      wait_cyc(41);
      check("out_step_state", state, 3);
      check("out_step_valid", display_valid, 0);
      check("out_step_display", display, 8'h3C);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      exp_q.push_back(43);
      wait_cyc(42);
      check("out_run_state", state, 0);
      check("out_display_hold", display, 8'h3C);
      set_button(1'b0);

      // Reset in WAIT_IN during the press cycle: no step.
      wait_cyc(44);
      drive(1'b1, 1'b0, 1'b0, 8'h5A, 8'h00);
      wait_cyc(48);
      check("abort_wait_state", state, 1);
      set_button(1'b1);
      wait_cyc(53);
      check("abort_press_state", state, 1);
      check("abort_in_data", in_data, 8'hA5);
      do_reset();

      // HALT with OUT on the same tick: halt wins, presses ignored.
      do_reset();
      drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h77);
      wait_cyc(4);
      check("halt_state", state, 4);
      check("halt_display", display, 0);
      check("halt_valid", display_valid, 0);
      for (int c = 5; c <= 55; c++) begin
         wait_cyc(c);
         if (c == 5 || c == 25) set_button(1'b1);
         if (c == 15 || c == 35) set_button(1'b0);
         check("halt_hold", state, 4);
      end
      do_reset();
      exp_q.push_back(3);
      wait_cyc(4);
      check("post_halt_state", state, 0);
      wait_cyc(5);
      check("sb_final", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
